// File: rtl/score_keeper_pkg.sv
// Shared types, constants and scoring helpers for the score_keeper block.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_SERVE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] PL_NONE = 2'b00;
  localparam logic [1:0] PL_1    = 2'b01;
  localparam logic [1:0] PL_2    = 2'b10;

  localparam int MAX_SCORE_DEF = 99;

  function automatic logic [7:0] sat_inc(input logic [7:0] s, input logic [7:0] max_s);
    logic [7:0] r;
    if (s >= max_s) begin
      r = max_s;
    end else begin
      r = s + 8'd1;
    end
    return r;
  endfunction

  // The lead is only formed when s is ahead, so the subtraction never wraps.
  function automatic logic is_win(input logic [7:0] s, input logic [7:0] other,
                                  input logic [7:0] win_score, input logic [7:0] win_margin,
                                  input logic [7:0] max_s);
    logic [7:0] lead;
    if (s > other) begin
      lead = s - other;
    end else begin
      lead = 8'd0;
    end
    return (s == max_s) || ((s >= win_score) && (lead >= win_margin));
  endfunction

endpackage

// File: rtl/score_keeper_rise_detect.sv
// Rising-edge detector: one registered pulse per 0->1 transition of a level input.
module score_keeper_rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic pulse
);

  logic prev_r;
  logic pulse_r;

  // Remember the last level and flag a low-to-high change one cycle later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      prev_r  <= d;
      pulse_r <= d & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/score_keeper.sv
// Score state for two players: counts single points from hit levels, serve lockout,
// win detection by threshold/margin or saturation ceiling.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int WIN_MARGIN  = 2,
  parameter int SERVE_DELAY = 50,
  parameter int MAX_SCORE   = MAX_SCORE_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score,
  output logic       serve_ready,
  output logic [1:0] last_scorer,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(SERVE_DELAY - 1);
  localparam logic [DW-1:0] DELAY_ONE  = DW'(1);
  localparam logic [DW-1:0] DELAY_ZERO = DW'(0);
  localparam logic [7:0]    WIN_S8     = 8'(WIN_SCORE);
  localparam logic [7:0]    MARGIN8    = 8'(WIN_MARGIN);
  localparam logic [7:0]    MAX8       = 8'(MAX_SCORE);

  logic start_rise_s, p1_rise_s, p2_rise_s;

  state_t        state_r, state_nxt_s;
  logic [7:0]    p1_score_r, p1_score_nxt_s, p1_inc_s;
  logic [7:0]    p2_score_r, p2_score_nxt_s, p2_inc_s;
  logic [1:0]    last_r, last_nxt_s;
  logic [1:0]    winner_r, winner_nxt_s;
  logic [DW-1:0] delay_r, delay_nxt_s;
  logic          serve_ready_r, serve_ready_nxt_s;
  logic          game_over_r, game_over_nxt_s;

  score_keeper_rise_detect u_rise_start (.clk(clk), .resetn(resetn), .d(start),  .pulse(start_rise_s));
  score_keeper_rise_detect u_rise_p1    (.clk(clk), .resetn(resetn), .d(p1_hit), .pulse(p1_rise_s));
  score_keeper_rise_detect u_rise_p2    (.clk(clk), .resetn(resetn), .d(p2_hit), .pulse(p2_rise_s));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus score/counter updates; a start edge overrides everything
  always_comb begin
    state_nxt_s    = state_r;
    p1_score_nxt_s = p1_score_r;
    p2_score_nxt_s = p2_score_r;
    last_nxt_s     = last_r;
    winner_nxt_s   = winner_r;
    delay_nxt_s    = delay_r;
    p1_inc_s       = sat_inc(p1_score_r, MAX8);
    p2_inc_s       = sat_inc(p2_score_r, MAX8);
    if (start_rise_s) begin
      state_nxt_s    = ST_PLAY;
      p1_score_nxt_s = 8'd0;
      p2_score_nxt_s = 8'd0;
      last_nxt_s     = PL_NONE;
      winner_nxt_s   = PL_NONE;
      delay_nxt_s    = DELAY_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_PLAY: begin
          if (p1_rise_s && !p2_rise_s) begin
            p1_score_nxt_s = p1_inc_s;
            last_nxt_s     = PL_1;
            delay_nxt_s    = DELAY_LOAD;
            if (is_win(p1_inc_s, p2_score_r, WIN_S8, MARGIN8, MAX8)) begin
              state_nxt_s  = ST_OVER;
              winner_nxt_s = PL_1;
            end else begin
              state_nxt_s  = ST_SERVE;
            end
          end else if (p2_rise_s && !p1_rise_s) begin
            p2_score_nxt_s = p2_inc_s;
            last_nxt_s     = PL_2;
            delay_nxt_s    = DELAY_LOAD;
            if (is_win(p2_inc_s, p1_score_r, WIN_S8, MARGIN8, MAX8)) begin
              state_nxt_s  = ST_OVER;
              winner_nxt_s = PL_2;
            end else begin
              state_nxt_s  = ST_SERVE;
            end
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end
        ST_SERVE: begin
          if (delay_r == DELAY_ZERO) begin
            state_nxt_s = ST_PLAY;
          end else begin
            delay_nxt_s = delay_r - DELAY_ONE;
          end
        end
        ST_OVER: state_nxt_s = ST_OVER;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Status flags decoded from the upcoming state so they register alongside it
  always_comb begin
    serve_ready_nxt_s = 1'b0;
    game_over_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_PLAY: serve_ready_nxt_s = 1'b1;
      ST_OVER: game_over_nxt_s   = 1'b1;
      default: begin
        serve_ready_nxt_s = 1'b0;
        game_over_nxt_s   = 1'b0;
      end
    endcase
  end

  // Score, counter and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p1_score_r    <= 8'd0;
      p2_score_r    <= 8'd0;
      last_r        <= PL_NONE;
      winner_r      <= PL_NONE;
      delay_r       <= DELAY_ZERO;
      serve_ready_r <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      p1_score_r    <= p1_score_nxt_s;
      p2_score_r    <= p2_score_nxt_s;
      last_r        <= last_nxt_s;
      winner_r      <= winner_nxt_s;
      delay_r       <= delay_nxt_s;
      serve_ready_r <= serve_ready_nxt_s;
      game_over_r   <= game_over_nxt_s;
    end
  end

  assign p1_score    = p1_score_r;
  assign p2_score    = p2_score_r;
  assign last_scorer = last_r;
  assign winner      = winner_r;
  assign serve_ready = serve_ready_r;
  assign game_over   = game_over_r;

endmodule
